// File: rtl/alu_8_op_pkg.sv
// Shared widths and opcode encodings for the 64-bit eight-operation ALU.
// Latency: none (constants only).
// Backpressure: none.
package alu_8_op_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic 64-bit barrel shifter, left or right, zero fill.
// Latency: combinational.
// Backpressure: none.
module alu_shifter
    import alu_8_op_pkg::*;
(
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               left,
    output logic [DATA_W-1:0]  dout
);

    logic [DATA_W-1:0] stage;

    // Stage i shifts by 2**i when shamt bit i is set.
    always_comb begin
        stage = din;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) begin
                if (left) begin
                    stage = stage << (1 << i);
                end else begin
                    stage = stage >> (1 << i);
                end
            end
        end
        dout = stage;
    end

endmodule

// File: rtl/alu_8_op.sv
// Eight-operation 64-bit ALU for the execute stage, result registered.
// Latency: one cycle from input sampling edge to Output.
// Backpressure: none; every rising edge loads a new result.
module alu_8_op
    import alu_8_op_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic [SHAMT_W-1:0] Shiftamt,
    input  logic [2:0]         Sel,
    output logic [DATA_W-1:0]  Output
);

    logic              sub;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;
    logic              lt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] result;

    // SUB and CMP share one adder: A + ~B + 1; no carry-out means a borrow, i.e. A < B unsigned.
    assign sub  = (Sel == OP_SUB) || (Sel == OP_CMP);
    assign b_op = sub ? ~B : B;
    assign sum  = {1'b0, A} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    assign lt   = ~sum[DATA_W];

    alu_shifter u_shifter (
        .din   (A),
        .shamt (Shiftamt),
        .left  (Sel == OP_SLL),
        .dout  (shifted)
    );

    always_comb begin
        result = '0;
        case (Sel)
            OP_ADD:  result = sum[DATA_W-1:0];
            OP_SUB:  result = sum[DATA_W-1:0];
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_AND:  result = A & B;
            OP_CMP:  result = {{(DATA_W-1){1'b0}}, lt};
            OP_SLL:  result = shifted;
            OP_SRL:  result = shifted;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Output <= '0;
        end else begin
            Output <= result;
        end
    end

endmodule

// File: tb/tb_alu_8_op.sv
// Directed-vector bench for alu_8_op with hand-computed expected results.
// Inputs change on falling edges; Output is sampled 1 ns after rising edges.
module tb_alu_8_op;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [5:0]  Shiftamt = '0;
    logic [2:0]  Sel = '0;
    logic [63:0] Output;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] VA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] VB = 64'hBBBB_BBBB_BBBB_BBBB;

    alu_8_op dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Shiftamt (Shiftamt),
        .Sel      (Sel),
        .Output   (Output)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] sh, input logic [2:0] sel, input logic [63:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        Shiftamt = sh;
        Sel = sel;
        @(posedge clk);
        #1;
        check_eq(tag, Output, exp);
    endtask

    logic [63:0] pipe_exp [8];

    initial begin
        pipe_exp[0] = 64'h6666_6666_6666_6665;
        pipe_exp[1] = 64'hEEEE_EEEE_EEEE_EEEF;
        pipe_exp[2] = 64'hBBBB_BBBB_BBBB_BBBB;
        pipe_exp[3] = 64'h1111_1111_1111_1111;
        pipe_exp[4] = 64'hAAAA_AAAA_AAAA_AAAA;
        pipe_exp[5] = 64'h0000_0000_0000_0001;
        pipe_exp[6] = 64'hAAAA_AAAA_AAAA_AAA0;
        pipe_exp[7] = 64'h0AAA_AAAA_AAAA_AAAA;

        // Reset asserts before the first clock edge.
        A = VA;
        B = VB;
        Sel = 3'b000;
        #1 rst = 1'b1;
        #1 check_eq("reset_async", Output, 64'h0);
        @(posedge clk);
        #1 check_eq("reset_held", Output, 64'h0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_eq("release_add", Output, 64'h6666_6666_6666_6665);

        run_op("add",          VA, VB, 6'd0,  3'b000, 64'h6666_6666_6666_6665);
        run_op("add_shamt_ign", VA, VB, 6'd5, 3'b000, 64'h6666_6666_6666_6665);
        run_op("add_wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 6'd0, 3'b000, 64'h1);
        run_op("sub",          VA, VB, 6'd0,  3'b001, 64'hEEEE_EEEE_EEEE_EEEF);
        run_op("sub_swap",     VB, VA, 6'd0,  3'b001, 64'h1111_1111_1111_1111);
        run_op("or",           VA, VB, 6'd0,  3'b010, 64'hBBBB_BBBB_BBBB_BBBB);
        run_op("xor",          VA, VB, 6'd0,  3'b011, 64'h1111_1111_1111_1111);
        run_op("and",          VA, VB, 6'd0,  3'b100, 64'hAAAA_AAAA_AAAA_AAAA);
        run_op("cmp_lt",       VA, VB, 6'd0,  3'b101, 64'h1);
        run_op("cmp_gt",       VB, VA, 6'd0,  3'b101, 64'h0);
        run_op("cmp_eq",       VA, VA, 6'd0,  3'b101, 64'h0);
        run_op("cmp_unsigned", 64'h8000_0000_0000_0000, 64'h1, 6'd0, 3'b101, 64'h0);
        run_op("cmp_msb_b",    64'h1, 64'h8000_0000_0000_0000, 6'd0, 3'b101, 64'h1);
        run_op("sll4",         VA, VB, 6'd4,  3'b110, 64'hAAAA_AAAA_AAAA_AAA0);
        run_op("srl4",         VA, VB, 6'd4,  3'b111, 64'h0AAA_AAAA_AAAA_AAAA);
        run_op("sll0",         VA, VB, 6'd0,  3'b110, VA);
        run_op("srl0",         VA, VB, 6'd0,  3'b111, VA);
        run_op("sll63",        VA, VB, 6'd63, 3'b110, 64'h0);
        run_op("sll63_one",    64'h1, VB, 6'd63, 3'b110, 64'h8000_0000_0000_0000);
        run_op("srl63_msb",    64'h8000_0000_0000_0000, VB, 6'd63, 3'b111, 64'h1);
        run_op("srl33",        64'hF000_0000_0000_0000, VB, 6'd33, 3'b111, 64'h0000_0000_7800_0000);

        // Back-to-back opcodes, one per cycle.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("pipe_sel%0d", i), VA, VB, 6'd4, 3'(i), pipe_exp[i]);
        end

        // Inputs changed mid-cycle must not disturb the registered result.
        #2;
        A = 64'h0;
        Sel = 3'b000;
        #1 check_eq("hold_midcycle", Output, 64'h0AAA_AAAA_AAAA_AAAA);

        // Reset in the middle of a sequence, then resume.
        run_op("pre_rst_xor", VA, VB, 6'd0, 3'b011, 64'h1111_1111_1111_1111);
        #2 rst = 1'b1;
        #1 check_eq("midrst_async", Output, 64'h0);
        @(negedge clk);
        A = VA;
        B = VB;
        Sel = 3'b000;
        @(posedge clk);
        #1 check_eq("midrst_held", Output, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_eq("resume_add", Output, 64'h6666_6666_6666_6665);
        run_op("resume_sub", VA, VB, 6'd0, 3'b001, 64'hEEEE_EEEE_EEEE_EEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
